// File: rtl/gpio_apb_pkg.sv
// gpio_apb_pkg: shared constants for the APB GPIO controller with edge interrupts.
// Holds the register word-index map and the parameter range limits used by
// gpio_apb_irq and gpio_in_sync.
package gpio_apb_pkg;

  // Upper bound on the pin count; one 32-bit APB word covers every pin.
  localparam int unsigned MAX_PINS       = 32;

  // Largest supported number of access-phase wait states and the counter width
  // needed to reach it.
  localparam int unsigned MAX_PREADY_DEL = 3;
  localparam int unsigned WAIT_CNT_W     = 2;

  // Register word indices on paddr.
  localparam int unsigned ADDR_OE      = 0;
  localparam int unsigned ADDR_PU      = 1;
  localparam int unsigned ADDR_PD      = 2;
  localparam int unsigned ADDR_A       = 3;
  localparam int unsigned ADDR_Y       = 4;
  localparam int unsigned ADDR_RISE_EN = 5;
  localparam int unsigned ADDR_FALL_EN = 6;
  localparam int unsigned ADDR_STATUS  = 7;

endpackage

// File: rtl/gpio_in_sync.sv
// gpio_in_sync: pad input synchroniser plus one history flop for edge detection.
// Ports: clk_i/rst_ni (sync, active-low), y_i async pads in; y_s_o synchronised
// value, rise_raw_o / fall_raw_o one-cycle edge pulses (not yet masked by enables).
module gpio_in_sync
  import gpio_apb_pkg::*;
#(
  parameter int N_PINS      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [N_PINS-1:0] y_i,
  output logic [N_PINS-1:0] y_s_o,
  output logic [N_PINS-1:0] rise_raw_o,
  output logic [N_PINS-1:0] fall_raw_o
);

  // Stage 0 is the metastability-catching flop; the last stage is y_s.
  logic [SYNC_STAGES-1:0][N_PINS-1:0] sync_q;
  logic [N_PINS-1:0]                  y_d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= '0;
      y_d_q  <= '0;
    end else begin
      sync_q[0] <= y_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      y_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign y_s_o = sync_q[SYNC_STAGES-1];

  // History flop clears on reset, so a pin already high looks like a rise for
  // one cycle after reset; the enables are still zero then, so nothing latches.
  assign rise_raw_o = y_s_o & ~y_d_q;
  assign fall_raw_o = ~y_s_o & y_d_q;

endmodule

// File: rtl/gpio_apb_irq.sv
// gpio_apb_irq: N_PINS GPIO controller on an APB3 slave with per-pin edge interrupts.
// Ports: APB3 slave (pclk, presetn sync active-low, paddr word index, pselx/penable,
// pwrite/pwdata, prdata/pready/pslverr); pads y in, oe/pu/pd/a out; irq level-high.
module gpio_apb_irq
  import gpio_apb_pkg::*;
#(
  parameter int N_PINS      = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 3,
  parameter int PREADY_DEL  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic                  pselx,
  input  logic                  penable,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  input  logic [N_PINS-1:0]     y,
  output logic [N_PINS-1:0]     oe,
  output logic [N_PINS-1:0]     pu,
  output logic [N_PINS-1:0]     pd,
  output logic [N_PINS-1:0]     a,
  output logic                  irq
);

  // Wait-state target, saturated to what the counter can represent.
  localparam logic [WAIT_CNT_W-1:0] PDEL =
    (PREADY_DEL > int'(MAX_PREADY_DEL)) ? WAIT_CNT_W'(MAX_PREADY_DEL)
                                        : WAIT_CNT_W'(PREADY_DEL);

  // Register indices sized to paddr so compares and case items match widths.
  localparam logic [ADDR_WIDTH-1:0] A_OE      = ADDR_WIDTH'(ADDR_OE);
  localparam logic [ADDR_WIDTH-1:0] A_PU      = ADDR_WIDTH'(ADDR_PU);
  localparam logic [ADDR_WIDTH-1:0] A_PD      = ADDR_WIDTH'(ADDR_PD);
  localparam logic [ADDR_WIDTH-1:0] A_A       = ADDR_WIDTH'(ADDR_A);
  localparam logic [ADDR_WIDTH-1:0] A_Y       = ADDR_WIDTH'(ADDR_Y);
  localparam logic [ADDR_WIDTH-1:0] A_RISE_EN = ADDR_WIDTH'(ADDR_RISE_EN);
  localparam logic [ADDR_WIDTH-1:0] A_FALL_EN = ADDR_WIDTH'(ADDR_FALL_EN);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS  = ADDR_WIDTH'(ADDR_STATUS);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [N_PINS-1:0]     oe_q, oe_d;
  logic [N_PINS-1:0]     pu_q, pu_d;
  logic [N_PINS-1:0]     pd_q, pd_d;
  logic [N_PINS-1:0]     a_q, a_d;
  logic [N_PINS-1:0]     rise_en_q, rise_en_d;
  logic [N_PINS-1:0]     fall_en_q, fall_en_d;
  logic [N_PINS-1:0]     status_q, status_d;
  logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge detect
  // ---------------------------------------------------------------------------
  logic [N_PINS-1:0] y_s;
  logic [N_PINS-1:0] rise_raw;
  logic [N_PINS-1:0] fall_raw;

  gpio_in_sync #(
    .N_PINS      (N_PINS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk_i      (pclk),
    .rst_ni     (presetn),
    .y_i        (y),
    .y_s_o      (y_s),
    .rise_raw_o (rise_raw),
    .fall_raw_o (fall_raw)
  );

  // ---------------------------------------------------------------------------
  // APB handshake
  // ---------------------------------------------------------------------------
  logic              access;
  logic              wr_en;
  logic              rd_en;
  logic [N_PINS-1:0] wdat;
  logic [N_PINS-1:0] w1c_mask;
  logic [N_PINS-1:0] rd_val;
  logic              unused_pwdata;

  assign access = pselx & penable;

  // Gated by presetn so pready stays low while reset is held, even with zero
  // wait states and a master still driving the access phase.
  assign pready  = presetn & access & (wait_cnt_q == PDEL);

  // Y is read-only: a write there completes with an error and is dropped.
  assign pslverr = pready & pwrite & (paddr == A_Y);
  assign wr_en   = pready & pwrite & (paddr != A_Y);
  assign rd_en   = pready & ~pwrite;

  assign wdat          = pwdata[N_PINS-1:0];
  assign unused_pwdata = ^pwdata;

  // Counter restarts whenever the access phase ends, whether it completed or
  // the master withdrew pselx.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!access || pready) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register writes
  // ---------------------------------------------------------------------------
  always_comb begin
    oe_d      = oe_q;
    pu_d      = pu_q;
    pd_d      = pd_q;
    a_d       = a_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_mask  = '0;
    if (wr_en) begin
      case (paddr)
        A_OE:      oe_d      = wdat;
        A_PU:      pu_d      = wdat;
        A_PD:      pd_d      = wdat;
        A_A:       a_d       = wdat;
        A_RISE_EN: rise_en_d = wdat;
        A_FALL_EN: fall_en_d = wdat;
        A_STATUS:  w1c_mask  = wdat;
        default:   ;
      endcase
    end
  end

  // Clear is applied before the new edges are OR-ed in, so an edge arriving in
  // the same cycle as its W1C is not lost.
  assign status_d = (status_q & ~w1c_mask)
                  | (rise_raw & rise_en_q)
                  | (fall_raw & fall_en_q);

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      oe_q       <= '0;
      pu_q       <= '0;
      pd_q       <= '0;
      a_q        <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      wait_cnt_q <= '0;
    end else begin
      oe_q       <= oe_d;
      pu_q       <= pu_d;
      pd_q       <= pd_d;
      a_q        <= a_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux: only drives data during a completing read, zero otherwise.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_val = '0;
    if (rd_en) begin
      case (paddr)
        A_OE:      rd_val = oe_q;
        A_PU:      rd_val = pu_q;
        A_PD:      rd_val = pd_q;
        A_A:       rd_val = a_q;
        A_Y:       rd_val = y_s;
        A_RISE_EN: rd_val = rise_en_q;
        A_FALL_EN: rd_val = fall_en_q;
        A_STATUS:  rd_val = status_q;
        default:   rd_val = '0;
      endcase
    end
  end

  assign prdata = DATA_WIDTH'(rd_val);

  // ---------------------------------------------------------------------------
  // Pad and interrupt outputs
  // ---------------------------------------------------------------------------
  assign oe  = oe_q;
  assign pu  = pu_q;
  assign pd  = pd_q;
  assign a   = a_q;
  assign irq = |status_q;

endmodule
